// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: bridges icache/dcache refills, dcache write-backs and
// uncached loads/stores onto one AXI-style burst read channel and one burst
// write channel. Read and write FSMs run concurrently; a read whose line is
// being written is held off until the write completes.
// Optional build macro: CACHE_AXI_RR_EN selects round-robin dcache/icache
// arbitration; without it dcache always beats icache.
module cache_axi_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_ren_i,
  input  logic [ADDR_W-1:0]        inst_araddr_i,
  output logic                     inst_rvalid_o,
  output logic [32*LINE_WORDS-1:0] inst_rdata_o,
  input  logic                     data_ren_i,
  input  logic [ADDR_W-1:0]        data_araddr_i,
  output logic                     data_rvalid_o,
  output logic [32*LINE_WORDS-1:0] data_rdata_o,
  input  logic                     data_wen_i,
  input  logic [ADDR_W-1:0]        data_awaddr_i,
  input  logic [32*LINE_WORDS-1:0] data_wdata_i,
  output logic                     data_bvalid_o,
  input  logic                     unc_ren_i,
  input  logic [ADDR_W-1:0]        unc_raddr_i,
  output logic                     unc_rvalid_o,
  output logic [31:0]              unc_rdata_o,
  input  logic [3:0]               unc_wen_i,
  input  logic [ADDR_W-1:0]        unc_waddr_i,
  input  logic [31:0]              unc_wdata_i,
  output logic                     unc_bvalid_o,
  output logic                     dev_rrdy_o,
  output logic                     dev_wrdy_o,
  output logic                     axi_ren_o,
  output logic [ADDR_W-1:0]        axi_raddr_o,
  output logic [7:0]               axi_rlen_o,
  output logic                     axi_rready_o,
  input  logic [31:0]              axi_rdata_i,
  input  logic                     axi_rvalid_i,
  output logic                     axi_wen_o,
  output logic [ADDR_W-1:0]        axi_waddr_o,
  output logic [31:0]              axi_wdata_o,
  output logic [3:0]               axi_wstrb_o,
  output logic                     axi_wlast_o,
  output logic [7:0]               axi_wlen_o,
  input  logic                     axi_wready_i,
  input  logic                     axi_bvalid_i
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF   = CNT_W + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_FREE, R_INST, R_DATA, R_UNC} r_state_t;
  typedef enum logic [1:0] {W_FREE, W_DATA, W_RESP}        w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  // ---------------- write side ----------------
  logic [ADDR_W-1:0]             w_addr;
  logic [LINE_WORDS-1:0][31:0]   w_line;
  logic [3:0]                    w_strb;
  logic                          w_unc;
  logic [CNT_W-1:0]              w_cnt;
  logic                          w_acc_unc, w_acc_data, w_last_beat;

  assign w_acc_unc   = (w_state == W_FREE) && (|unc_wen_i);
  assign w_acc_data  = (w_state == W_FREE) && !(|unc_wen_i) && data_wen_i;
  assign w_last_beat = w_unc || (w_cnt == LAST_BEAT);

  // write state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) w_state <= W_FREE;
    else      w_state <= w_next;

  // write next state: bvalid is only honoured once the last beat has gone
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_FREE:  if (w_acc_unc || w_acc_data)     w_next = W_DATA;
      W_DATA:  if (axi_wready_i && w_last_beat) w_next = W_RESP;
      W_RESP:  if (axi_bvalid_i)                w_next = W_FREE;
      default:                                  w_next = W_FREE;
    endcase
  end

  // write channel outputs, all zero while idle
  always_comb begin
    axi_wen_o   = 1'b0;
    axi_waddr_o = '0;
    axi_wdata_o = '0;
    axi_wstrb_o = '0;
    axi_wlast_o = 1'b0;
    axi_wlen_o  = '0;
    dev_wrdy_o  = (w_state == W_FREE);
    if (w_state != W_FREE) begin
      axi_wen_o   = 1'b1;
      axi_waddr_o = w_addr;
      axi_wdata_o = w_line[w_cnt];
      axi_wstrb_o = w_strb;
      axi_wlen_o  = w_unc ? 8'd0 : 8'(LINE_WORDS - 1);
    end
    if (w_state == W_DATA) axi_wlast_o = w_last_beat;
  end

  // write datapath: capture request at acceptance, step beats, done pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_addr        <= '0;
      w_line        <= '0;
      w_strb        <= '0;
      w_unc         <= 1'b0;
      w_cnt         <= '0;
      data_bvalid_o <= 1'b0;
      unc_bvalid_o  <= 1'b0;
    end else begin
      data_bvalid_o <= (w_state == W_RESP) && axi_bvalid_i && !w_unc;
      unc_bvalid_o  <= (w_state == W_RESP) && axi_bvalid_i &&  w_unc;
      if (w_acc_unc) begin
        // the store word rides in beat 0 of the line buffer
        w_addr <= unc_waddr_i;
        w_line <= (32*LINE_WORDS)'(unc_wdata_i);
        w_strb <= unc_wen_i;
        w_unc  <= 1'b1;
        w_cnt  <= '0;
      end else if (w_acc_data) begin
        w_addr <= data_awaddr_i & LINE_MASK;
        w_line <= data_wdata_i;
        w_strb <= 4'hF;
        w_unc  <= 1'b0;
        w_cnt  <= '0;
      end else if (w_state == W_DATA && axi_wready_i && !w_last_beat) begin
        w_cnt <= w_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------- read hazard and arbitration ----------------
  logic              w_busy, data_ok, unc_ok;
  logic [ADDR_W-1:0] hz_addr;
  logic              gnt_unc, gnt_data, gnt_inst;

  // a write accepted this very cycle already blocks its line
  assign w_busy  = (w_state != W_FREE) || w_acc_unc || w_acc_data;
  assign hz_addr = w_acc_unc ? unc_waddr_i : (w_acc_data ? data_awaddr_i : w_addr);
  assign data_ok = data_ren_i &&
                   !(w_busy && ((data_araddr_i & LINE_MASK) == (hz_addr & LINE_MASK)));
  assign unc_ok  = unc_ren_i &&
                   !(w_busy && ((unc_raddr_i & LINE_MASK) == (hz_addr & LINE_MASK)));
  assign gnt_unc = unc_ok;

`ifdef CACHE_AXI_RR_EN
  logic prio_inst;

  assign gnt_data = !unc_ok && data_ok && (!inst_ren_i || !prio_inst);
  assign gnt_inst = !unc_ok && inst_ren_i && (!data_ok || prio_inst);

  // hand priority to whichever line requester did not just win
  always_ff @(posedge clk or negedge rst)
    if (!rst) prio_inst <= 1'b0;
    else if (r_state == R_FREE && (gnt_data || gnt_inst)) prio_inst <= gnt_data;
`else
  assign gnt_data = !unc_ok && data_ok;
  assign gnt_inst = !unc_ok && !data_ok && inst_ren_i;
`endif

  // ---------------- read side ----------------
  logic [ADDR_W-1:0]           r_addr;
  logic [CNT_W-1:0]            r_cnt;
  logic [LINE_WORDS-1:0][31:0] inst_line, data_line;
  logic [31:0]                 unc_word;
  logic                        r_last;

  assign r_last       = (r_cnt == LAST_BEAT);
  assign inst_rdata_o = inst_line;
  assign data_rdata_o = data_line;
  assign unc_rdata_o  = unc_word;

  // read state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= R_FREE;
    else      r_state <= r_next;

  // read next state: one grant per idle cycle, leave on the last beat
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_FREE: begin
        if      (gnt_unc)  r_next = R_UNC;
        else if (gnt_data) r_next = R_DATA;
        else if (gnt_inst) r_next = R_INST;
      end
      R_INST, R_DATA: if (axi_rvalid_i && r_last) r_next = R_FREE;
      R_UNC:          if (axi_rvalid_i)           r_next = R_FREE;
      default:                                    r_next = R_FREE;
    endcase
  end

  // read channel outputs, all zero while idle
  always_comb begin
    axi_ren_o    = (r_state != R_FREE);
    axi_rready_o = (r_state != R_FREE);
    dev_rrdy_o   = (r_state == R_FREE);
    axi_raddr_o  = (r_state == R_FREE) ? '0 : r_addr;
    axi_rlen_o   = (r_state == R_INST || r_state == R_DATA) ? 8'(LINE_WORDS - 1) : 8'd0;
  end

  // read datapath: latch granted address, scatter beats, done pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr        <= '0;
      r_cnt         <= '0;
      inst_line     <= '0;
      data_line     <= '0;
      unc_word      <= '0;
      inst_rvalid_o <= 1'b0;
      data_rvalid_o <= 1'b0;
      unc_rvalid_o  <= 1'b0;
    end else begin
      inst_rvalid_o <= (r_state == R_INST) && axi_rvalid_i && r_last;
      data_rvalid_o <= (r_state == R_DATA) && axi_rvalid_i && r_last;
      unc_rvalid_o  <= (r_state == R_UNC)  && axi_rvalid_i;
      if (r_state == R_FREE) begin
        r_cnt <= '0;
        if      (gnt_unc)  r_addr <= unc_raddr_i;
        else if (gnt_data) r_addr <= data_araddr_i & LINE_MASK;
        else if (gnt_inst) r_addr <= inst_araddr_i & LINE_MASK;
      end else if (axi_rvalid_i) begin
        case (r_state)
          R_INST:  inst_line[r_cnt] <= axi_rdata_i;
          R_DATA:  data_line[r_cnt] <= axi_rdata_i;
          default: unc_word         <= axi_rdata_i;
        endcase
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter (LINE_WORDS=4, ADDR_W=32).
module tb_cache_axi_arbiter;
  localparam int LW = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          inst_ren_i = 0, data_ren_i = 0, data_wen_i = 0, unc_ren_i = 0;
  logic [31:0]   inst_araddr_i = 0, data_araddr_i = 0, data_awaddr_i = 0;
  logic [31:0]   unc_raddr_i = 0, unc_waddr_i = 0, unc_wdata_i = 0;
  logic [127:0]  data_wdata_i = 0;
  logic [3:0]    unc_wen_i = 0;
  logic [31:0]   axi_rdata_i = 0;
  logic          axi_rvalid_i = 0, axi_wready_i = 0, axi_bvalid_i = 0;
  logic          inst_rvalid_o, data_rvalid_o, data_bvalid_o, unc_rvalid_o, unc_bvalid_o;
  logic [127:0]  inst_rdata_o, data_rdata_o;
  logic [31:0]   unc_rdata_o;
  logic          dev_rrdy_o, dev_wrdy_o, axi_ren_o, axi_rready_o;
  logic [31:0]   axi_raddr_o, axi_waddr_o, axi_wdata_o;
  logic [7:0]    axi_rlen_o, axi_wlen_o;
  logic          axi_wen_o, axi_wlast_o;
  logic [3:0]    axi_wstrb_o;

  int n_chk = 0;
  int n_fail = 0;

  cache_axi_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_ren_i(inst_ren_i), .inst_araddr_i(inst_araddr_i),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_ren_i(data_ren_i), .data_araddr_i(data_araddr_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_wen_i(data_wen_i), .data_awaddr_i(data_awaddr_i),
    .data_wdata_i(data_wdata_i), .data_bvalid_o(data_bvalid_o),
    .unc_ren_i(unc_ren_i), .unc_raddr_i(unc_raddr_i),
    .unc_rvalid_o(unc_rvalid_o), .unc_rdata_o(unc_rdata_o),
    .unc_wen_i(unc_wen_i), .unc_waddr_i(unc_waddr_i), .unc_wdata_i(unc_wdata_i),
    .unc_bvalid_o(unc_bvalid_o),
    .dev_rrdy_o(dev_rrdy_o), .dev_wrdy_o(dev_wrdy_o),
    .axi_ren_o(axi_ren_o), .axi_raddr_o(axi_raddr_o), .axi_rlen_o(axi_rlen_o),
    .axi_rready_o(axi_rready_o), .axi_rdata_i(axi_rdata_i), .axi_rvalid_i(axi_rvalid_i),
    .axi_wen_o(axi_wen_o), .axi_waddr_o(axi_waddr_o), .axi_wdata_o(axi_wdata_o),
    .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o), .axi_wlen_o(axi_wlen_o),
    .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // inputs change and outputs are sampled 1ns after each rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if (dev_rrdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rrdy got %b want 1", dev_rrdy_o); end
    n_chk++; if (dev_wrdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_wrdy got %b want 1", dev_wrdy_o); end
    n_chk++; if ({axi_ren_o, axi_wen_o, axi_rready_o} !== 3'b000) begin n_fail++; $display("FAIL reset_axi_en got %b want 000", {axi_ren_o, axi_wen_o, axi_rready_o}); end
    n_chk++; if (inst_rdata_o !== 128'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", inst_rdata_o); end
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_refill;
    logic [31:0] a [4];
    a = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    inst_ren_i = 1; inst_araddr_i = 32'h1C00_0014;
    tick;
    inst_ren_i = 0;
    n_chk++; if (axi_ren_o !== 1'b1) begin n_fail++; $display("FAIL refill_ren got %b want 1", axi_ren_o); end
    n_chk++; if (axi_raddr_o !== 32'h1C00_0010) begin n_fail++; $display("FAIL refill_raddr got %h want 1c000010", axi_raddr_o); end
    n_chk++; if (axi_rlen_o !== 8'd3) begin n_fail++; $display("FAIL refill_rlen got %0d want 3", axi_rlen_o); end
    for (int i = 0; i < 4; i++) begin
      axi_rvalid_i = 1; axi_rdata_i = a[i];
      tick;
      if (i == 1) begin axi_rvalid_i = 0; tick; end
    end
    axi_rvalid_i = 0;
    n_chk++; if (inst_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL refill_pulse got %b want 1", inst_rvalid_o); end
    n_chk++; if (inst_rdata_o !== {a[3], a[2], a[1], a[0]}) begin n_fail++; $display("FAIL refill_line got %h want %h", inst_rdata_o, {a[3], a[2], a[1], a[0]}); end
    n_chk++; if (axi_ren_o !== 1'b0) begin n_fail++; $display("FAIL refill_idle got %b want 0", axi_ren_o); end
    tick;
    n_chk++; if (inst_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL refill_pulse_len got %b want 0", inst_rvalid_o); end
  endtask

  task automatic test_writeback;
    logic [31:0] w [4];
    w = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    data_wen_i = 1; data_awaddr_i = 32'h8000_0040; data_wdata_i = {w[3], w[2], w[1], w[0]};
    tick;
    data_wen_i = 0;
    n_chk++; if (axi_wen_o !== 1'b1) begin n_fail++; $display("FAIL wb_wen got %b want 1", axi_wen_o); end
    n_chk++; if (axi_waddr_o !== 32'h8000_0040) begin n_fail++; $display("FAIL wb_waddr got %h want 80000040", axi_waddr_o); end
    n_chk++; if ({axi_wlen_o, axi_wstrb_o} !== {8'd3, 4'hF}) begin n_fail++; $display("FAIL wb_len_strb got %h/%h want 3/f", axi_wlen_o, axi_wstrb_o); end
    for (int k = 0; k < 4; k++) begin
      tick; tick;
      n_chk++; if (axi_wdata_o !== w[k]) begin n_fail++; $display("FAIL wb_beat%0d_data got %h want %h", k, axi_wdata_o, w[k]); end
      n_chk++; if (axi_wlast_o !== (k == 3)) begin n_fail++; $display("FAIL wb_beat%0d_wlast got %b want %b", k, axi_wlast_o, (k == 3)); end
      axi_wready_i = 1;
      if (k == 3) axi_bvalid_i = 1;
      tick;
      axi_wready_i = 0; axi_bvalid_i = 0;
    end
    n_chk++; if ({axi_wen_o, data_bvalid_o, dev_wrdy_o} !== 3'b100) begin n_fail++; $display("FAIL wb_resp got %b want 100", {axi_wen_o, data_bvalid_o, dev_wrdy_o}); end
    tick;
    n_chk++; if (axi_wen_o !== 1'b1) begin n_fail++; $display("FAIL wb_early_bvalid got %b want 1", axi_wen_o); end
    axi_bvalid_i = 1;
    tick;
    axi_bvalid_i = 0;
    n_chk++; if ({axi_wen_o, data_bvalid_o, dev_wrdy_o} !== 3'b011) begin n_fail++; $display("FAIL wb_done got %b want 011", {axi_wen_o, data_bvalid_o, dev_wrdy_o}); end
    tick;
    n_chk++; if (data_bvalid_o !== 1'b0) begin n_fail++; $display("FAIL wb_pulse_len got %b want 0", data_bvalid_o); end
  endtask

  task automatic test_hazard;
    data_wen_i = 1; data_awaddr_i = 32'h8000_0040; data_wdata_i = 128'h1;
    data_ren_i = 1; data_araddr_i = 32'h8000_0048;
    inst_ren_i = 1; inst_araddr_i = 32'h0000_1000;
    tick;
    data_wen_i = 0; inst_ren_i = 0;
    n_chk++; if (axi_raddr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL hz_inst_grant got %h want 00001000", axi_raddr_o); end
    for (int i = 0; i < 4; i++) begin axi_rvalid_i = 1; axi_rdata_i = 32'h1111_0000 + i; tick; end
    axi_rvalid_i = 0;
    n_chk++; if (inst_rdata_o !== 128'h11110003_11110002_11110001_11110000) begin n_fail++; $display("FAIL hz_inst_line got %h", inst_rdata_o); end
    tick; tick;
    n_chk++; if (axi_ren_o !== 1'b0) begin n_fail++; $display("FAIL hz_blocked_wdata got %b want 0", axi_ren_o); end
    axi_wready_i = 1;
    for (int i = 0; i < 4; i++) tick;
    axi_wready_i = 0;
    n_chk++; if (axi_ren_o !== 1'b0) begin n_fail++; $display("FAIL hz_blocked_wresp got %b want 0", axi_ren_o); end
    axi_bvalid_i = 1;
    tick;
    axi_bvalid_i = 0;
    n_chk++; if ({axi_ren_o, data_bvalid_o} !== 2'b01) begin n_fail++; $display("FAIL hz_release got %b want 01", {axi_ren_o, data_bvalid_o}); end
    tick;
    data_ren_i = 0;
    n_chk++; if ({axi_ren_o, axi_raddr_o} !== {1'b1, 32'h8000_0040}) begin n_fail++; $display("FAIL hz_data_grant got %b/%h want 1/80000040", axi_ren_o, axi_raddr_o); end
    for (int i = 0; i < 4; i++) begin axi_rvalid_i = 1; axi_rdata_i = 32'hD000_0000 + i; tick; end
    axi_rvalid_i = 0;
    n_chk++; if ({data_rvalid_o, data_rdata_o} !== {1'b1, 128'hD0000003_D0000002_D0000001_D0000000}) begin n_fail++; $display("FAIL hz_data_line got %b/%h", data_rvalid_o, data_rdata_o); end
    tick;
  endtask

  task automatic test_unc_store;
    unc_wen_i = 4'b0011; unc_waddr_i = 32'hBFD0_0000; unc_wdata_i = 32'hDEAD_BEEF;
    tick;
    unc_wen_i = 0;
    n_chk++; if ({axi_waddr_o, axi_wdata_o} !== {32'hBFD0_0000, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL us_addr_data got %h/%h", axi_waddr_o, axi_wdata_o); end
    n_chk++; if ({axi_wlen_o, axi_wstrb_o, axi_wlast_o} !== {8'd0, 4'b0011, 1'b1}) begin n_fail++; $display("FAIL us_len_strb_last got %h/%b/%b want 0/0011/1", axi_wlen_o, axi_wstrb_o, axi_wlast_o); end
    axi_wready_i = 1; tick; axi_wready_i = 0;
    axi_bvalid_i = 1; tick; axi_bvalid_i = 0;
    n_chk++; if ({unc_bvalid_o, data_bvalid_o, axi_wen_o} !== 3'b100) begin n_fail++; $display("FAIL us_done got %b want 100", {unc_bvalid_o, data_bvalid_o, axi_wen_o}); end
    tick;
  endtask

  task automatic test_unc_load;
    unc_ren_i = 1; unc_raddr_i = 32'hBFD0_0004;
    data_ren_i = 1; data_araddr_i = 32'h0000_4000;
    inst_ren_i = 1; inst_araddr_i = 32'h0000_5000;
    tick;
    unc_ren_i = 0; data_ren_i = 0; inst_ren_i = 0;
    n_chk++; if ({axi_raddr_o, axi_rlen_o} !== {32'hBFD0_0004, 8'd0}) begin n_fail++; $display("FAIL ul_grant got %h/%0d want bfd00004/0", axi_raddr_o, axi_rlen_o); end
    axi_rvalid_i = 1; axi_rdata_i = 32'hCAFE_F00D; tick; axi_rvalid_i = 0;
    n_chk++; if ({unc_rvalid_o, unc_rdata_o} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL ul_done got %b/%h want 1/cafef00d", unc_rvalid_o, unc_rdata_o); end
    tick;
  endtask

  task automatic test_arbitration;
    int t;
    logic got_d, want_d;
    rst = 0; #1; tick; rst = 1; tick;
    inst_ren_i = 1; inst_araddr_i = 32'h0000_2000;
    data_ren_i = 1; data_araddr_i = 32'h0000_3000;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      while (!axi_ren_o && t < 10) begin tick; t++; end
      n_chk++; if (!axi_ren_o) begin n_fail++; $display("FAIL arb_grant%0d timeout got ren %b want 1", g, axi_ren_o); end
      got_d = (axi_raddr_o == 32'h0000_3000);
`ifdef CACHE_AXI_RR_EN
      want_d = (g % 2 == 0);
`else
      want_d = 1'b1;
`endif
      n_chk++; if (got_d !== want_d) begin n_fail++; $display("FAIL arb_order%0d got dcache=%b want %b", g, got_d, want_d); end
      for (int i = 0; i < 4; i++) begin axi_rvalid_i = 1; axi_rdata_i = 32'h0; tick; end
      axi_rvalid_i = 0;
    end
    inst_ren_i = 0; data_ren_i = 0;
    tick;
  endtask

  task automatic test_midburst_reset;
    inst_ren_i = 1; inst_araddr_i = 32'h1C00_0100;
    tick;
    inst_ren_i = 0;
    for (int i = 0; i < 2; i++) begin axi_rvalid_i = 1; axi_rdata_i = 32'hEE00_0000 + i; tick; end
    rst = 0;
    #1;
    n_chk++; if ({axi_ren_o, axi_rready_o, axi_raddr_o, axi_rlen_o} !== '0) begin n_fail++; $display("FAIL mr_axi got %b/%h/%h want 0", axi_ren_o, axi_raddr_o, axi_rlen_o); end
    n_chk++; if ({inst_rdata_o, inst_rvalid_o, dev_rrdy_o} !== {128'h0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL mr_state got %h/%b/%b", inst_rdata_o, inst_rvalid_o, dev_rrdy_o); end
    axi_rvalid_i = 0;
    tick;
    rst = 1;
    tick;
    inst_ren_i = 1; inst_araddr_i = 32'h1C00_0204;
    tick;
    inst_ren_i = 0;
    n_chk++; if (axi_raddr_o !== 32'h1C00_0200) begin n_fail++; $display("FAIL mr_regrant got %h want 1c000200", axi_raddr_o); end
    for (int i = 0; i < 4; i++) begin axi_rvalid_i = 1; axi_rdata_i = 32'h5500_0000 + i; tick; end
    axi_rvalid_i = 0;
    n_chk++; if ({inst_rvalid_o, inst_rdata_o} !== {1'b1, 128'h55000003_55000002_55000001_55000000}) begin n_fail++; $display("FAIL mr_refill got %b/%h", inst_rvalid_o, inst_rdata_o); end
    tick;
  endtask

  initial begin
    test_reset;
    test_refill;
    test_writeback;
    test_hazard;
    test_unc_store;
    test_unc_load;
    test_arbitration;
    test_midburst_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
